// File: rtl/rupt_sequencer_if.sv
// Pipeline-side handshake of the interrupt sequencer: flush, vector injection and return-PC restore.
interface rupt_sequencer_if;
  logic        flush;
  logic        inject_valid;
  logic [11:0] inject_pc;
  logic        inject_ready;
  logic        restore_valid;
  logic [11:0] restore_pc;

  modport master (
    output flush, inject_valid, inject_pc, restore_valid, restore_pc,
    input  inject_ready
  );

  modport slave (
    input  flush, inject_valid, inject_pc, restore_valid, restore_pc,
    output inject_ready
  );
endinterface

// File: rtl/rupt_sequencer.sv
// Interrupt request arbitration and pipeline entry sequencing: waits for an instruction
// boundary, flushes, injects the vector PC, and restores the saved return PC on RESUME.
module rupt_sequencer #(
  parameter int unsigned NUM_RUPT   = 4,
  parameter int unsigned VEC_BASE   = 12'o4000,
  parameter int unsigned VEC_STRIDE = 4,
  parameter logic        RESET_IE   = 1'b1
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [NUM_RUPT-1:0] rupt_req,
  input  logic                retire,
  input  logic [11:0]         retire_pc,
  input  logic                extend_pend,
  input  logic                index_pend,
  input  logic                inhint,
  input  logic                relint,
  input  logic                resume,
  input  logic                halt,
  rupt_sequencer_if.master    pipe,
  output logic [NUM_RUPT-1:0] rupt_ack,
  output logic                in_isr,
  output logic                ie
);

  localparam int unsigned W = (NUM_RUPT > 1) ? $clog2(NUM_RUPT) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_BND, FLUSH, VECTOR, ISR} state_t;

  state_t              state;
  logic [NUM_RUPT-1:0] pending;
  logic [NUM_RUPT-1:0] req_q;
  logic [NUM_RUPT-1:0] pending_n;
  logic [NUM_RUPT-1:0] ack_clr;
  logic [11:0]         save_pc;
  logic [W-1:0]        winner;
  logic [W-1:0]        win_idx;
  logic                boundary;
  logic                fire;

  assign boundary = retire & ~extend_pend & ~index_pend;
  assign fire     = (state == VECTOR) & pipe.inject_valid & pipe.inject_ready & ~halt;

  always_comb begin
    win_idx = '0;
    for (int unsigned i = NUM_RUPT; i > 0; i--) begin
      if (pending[i-1]) win_idx = W'(i - 1);
    end
  end

  // Ack clears the winner's pending bit, but a fresh edge in the same cycle re-sets it.
  always_comb begin
    ack_clr   = fire ? (NUM_RUPT'(1) << winner) : '0;
    pending_n = (pending & ~ack_clr) | (rupt_req & ~req_q);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state              <= IDLE;
      pending            <= '0;
      req_q              <= '0;
      save_pc            <= '0;
      winner             <= '0;
      pipe.flush         <= 1'b0;
      pipe.inject_valid  <= 1'b0;
      pipe.inject_pc     <= '0;
      pipe.restore_valid <= 1'b0;
      pipe.restore_pc    <= '0;
      rupt_ack           <= '0;
      in_isr             <= 1'b0;
      ie                 <= RESET_IE;
    end else begin
      req_q   <= rupt_req;
      pending <= pending_n;
      if (!halt) begin
        pipe.flush         <= 1'b0;
        pipe.restore_valid <= 1'b0;
        pipe.restore_pc    <= '0;
        rupt_ack           <= '0;
        if (inhint)      ie <= 1'b0;
        else if (relint) ie <= 1'b1;
        case (state)
          IDLE: begin
            if (ie && |pending) state <= WAIT_BND;
          end
          WAIT_BND: begin
            if (!ie) begin
              state <= IDLE;
            end else if (boundary) begin
              save_pc    <= retire_pc + 12'd1;
              winner     <= win_idx;
              pipe.flush <= 1'b1;
              state      <= FLUSH;
            end
          end
          FLUSH: begin
            pipe.inject_valid <= 1'b1;
            pipe.inject_pc    <= 12'(VEC_BASE) + 12'(VEC_STRIDE) * 12'(winner);
            state             <= VECTOR;
          end
          VECTOR: begin
            if (fire) begin
              pipe.inject_valid <= 1'b0;
              pipe.inject_pc    <= '0;
              rupt_ack          <= NUM_RUPT'(1) << winner;
              ie                <= 1'b0;
              in_isr            <= 1'b1;
              state             <= ISR;
            end
          end
          ISR: begin
            if (resume) begin
              pipe.restore_valid <= 1'b1;
              pipe.restore_pc    <= save_pc;
              ie                 <= 1'b1;
              in_isr             <= 1'b0;
              state              <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
